// File: rtl/gg_nc_context_ctrl.sv
// Neighbour-context sequencer: walks macroblocks in raster order and supplies above/left nc contexts.
// Above-row nc values live in a line buffer indexed by mbx; left nc values live in registers.
module gg_nc_context_ctrl #(
    parameter int MAX_WIDTH_MB = 120,
    parameter int NC_W         = 8,
    parameter int DIM_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic [DIM_W-1:0]     pic_width_mb,
    input  logic [DIM_W-1:0]     pic_height_mb,
    output logic                 ctx_valid,
    output logic [DIM_W-1:0]     mbx,
    output logic [DIM_W-1:0]     mby,
    output logic                 abv_out_of_pic,
    output logic                 left_out_of_pic,
    output logic [4*NC_W-1:0]    above_nc_y,
    output logic [2*NC_W-1:0]    above_nc_cb,
    output logic [2*NC_W-1:0]    above_nc_cr,
    output logic [4*NC_W-1:0]    left_nc_y,
    output logic [2*NC_W-1:0]    left_nc_cb,
    output logic [2*NC_W-1:0]    left_nc_cr,
    input  logic                 mb_done,
    input  logic [4*NC_W-1:0]    below_nc_y,
    input  logic [2*NC_W-1:0]    below_nc_cb,
    input  logic [2*NC_W-1:0]    below_nc_cr,
    input  logic [4*NC_W-1:0]    right_nc_y,
    input  logic [2*NC_W-1:0]    right_nc_cb,
    input  logic [2*NC_W-1:0]    right_nc_cr,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cfg_err
);

    localparam int AW = (MAX_WIDTH_MB > 1) ? $clog2(MAX_WIDTH_MB) : 1;
    localparam int BW = 8 * NC_W;
    localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_WIDTH_MB);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_WRITE} state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] mbx_q, mbx_d, mby_q, mby_d;
    logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
    logic [BW-1:0]    left_q, left_d;
    logic [BW-1:0]    below_hold_q, below_hold_d;
    logic [BW-1:0]    right_hold_q, right_hold_d;
    logic             cfg_err_q, cfg_err_d;
    logic             frame_done_q, frame_done_d;
    logic [BW-1:0]    rd_data_q;
    logic [BW-1:0]    line_buf [0:MAX_WIDTH_MB-1];

    logic             dims_ok;
    logic             last_col, last_row;
    logic [AW-1:0]    buf_addr;

    assign dims_ok  = (pic_width_mb != '0) && (pic_width_mb <= MAX_W) && (pic_height_mb != '0);
    assign last_col = (mbx_q == width_q - DIM_W'(1));
    assign last_row = (mby_q == height_q - DIM_W'(1));
    assign buf_addr = mbx_q[AW-1:0];

    always_comb begin
        state_d      = state_q;
        mbx_d        = mbx_q;
        mby_d        = mby_q;
        width_d      = width_q;
        height_d     = height_q;
        left_d       = left_q;
        below_hold_d = below_hold_q;
        right_hold_d = right_hold_q;
        cfg_err_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    if (dims_ok) begin
                        width_d  = pic_width_mb;
                        height_d = pic_height_mb;
                        mbx_d    = '0;
                        mby_d    = '0;
                        left_d   = '0;
                        state_d  = S_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = S_READY;
            S_READY: begin
                if (mb_done) begin
                    below_hold_d = {below_nc_cr, below_nc_cb, below_nc_y};
                    right_hold_d = {right_nc_cr, right_nc_cb, right_nc_y};
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                left_d = right_hold_q;
                if (last_col && last_row) begin
                    mbx_d        = '0;
                    mby_d        = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (last_col) begin
                    mbx_d   = '0;
                    mby_d   = mby_q + DIM_W'(1);
                    state_d = S_LOAD;
                end else begin
                    mbx_d   = mbx_q + DIM_W'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mbx_q        <= '0;
            mby_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            left_q       <= '0;
            below_hold_q <= '0;
            right_hold_q <= '0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mbx_q        <= mbx_d;
            mby_q        <= mby_d;
            width_q      <= width_d;
            height_q     <= height_d;
            left_q       <= left_d;
            below_hold_q <= below_hold_d;
            right_hold_q <= right_hold_d;
            cfg_err_q    <= cfg_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Plain RAM: no reset, registered read in LOAD; WRITE and LOAD never overlap so no bypass.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) line_buf[buf_addr] <= below_hold_q;
        if (state_q == S_LOAD)  rd_data_q <= line_buf[buf_addr];
    end

    assign ctx_valid       = (state_q == S_READY);
    assign busy            = (state_q != S_IDLE);
    assign mbx             = mbx_q;
    assign mby             = mby_q;
    assign abv_out_of_pic  = busy && (mby_q == '0);
    assign left_out_of_pic = busy && (mbx_q == '0);
    assign frame_done      = frame_done_q;
    assign cfg_err         = cfg_err_q;

    // Edge MBs see zero context so stale buffer or previous-row data never leaks out.
    logic [BW-1:0] above_m, left_m;
    assign above_m = (ctx_valid && !abv_out_of_pic)  ? rd_data_q : '0;
    assign left_m  = (ctx_valid && !left_out_of_pic) ? left_q    : '0;

    assign above_nc_y  = above_m[4*NC_W-1:0];
    assign above_nc_cb = above_m[6*NC_W-1:4*NC_W];
    assign above_nc_cr = above_m[8*NC_W-1:6*NC_W];
    assign left_nc_y   = left_m[4*NC_W-1:0];
    assign left_nc_cb  = left_m[6*NC_W-1:4*NC_W];
    assign left_nc_cr  = left_m[8*NC_W-1:6*NC_W];

endmodule

// File: tb/tb_gg_nc_context_ctrl.sv
// Bench for gg_nc_context_ctrl: random frames checked against a per-frame table of expected contexts
// derived directly from the neighbour rules (above = previous row's below, left = previous MB's right).
module tb_gg_nc_context_ctrl;

    localparam int MAXW  = 120;
    localparam int NC_W  = 8;
    localparam int DIM_W = 8;
    localparam int BW    = 8 * NC_W;
    localparam int CW    = 2 * DIM_W + 2 + 2 * BW;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 frame_start;
    logic [DIM_W-1:0]     pic_width_mb, pic_height_mb;
    logic                 ctx_valid;
    logic [DIM_W-1:0]     mbx, mby;
    logic                 abv_out_of_pic, left_out_of_pic;
    logic [4*NC_W-1:0]    above_nc_y, left_nc_y, below_nc_y, right_nc_y;
    logic [2*NC_W-1:0]    above_nc_cb, above_nc_cr, left_nc_cb, left_nc_cr;
    logic [2*NC_W-1:0]    below_nc_cb, below_nc_cr, right_nc_cb, right_nc_cr;
    logic                 mb_done;
    logic                 busy, frame_done, cfg_err;

    gg_nc_context_ctrl #(.MAX_WIDTH_MB(MAXW), .NC_W(NC_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .pic_width_mb(pic_width_mb), .pic_height_mb(pic_height_mb),
        .ctx_valid(ctx_valid), .mbx(mbx), .mby(mby),
        .abv_out_of_pic(abv_out_of_pic), .left_out_of_pic(left_out_of_pic),
        .above_nc_y(above_nc_y), .above_nc_cb(above_nc_cb), .above_nc_cr(above_nc_cr),
        .left_nc_y(left_nc_y), .left_nc_cb(left_nc_cb), .left_nc_cr(left_nc_cr),
        .mb_done(mb_done),
        .below_nc_y(below_nc_y), .below_nc_cb(below_nc_cb), .below_nc_cr(below_nc_cr),
        .right_nc_y(right_nc_y), .right_nc_cb(right_nc_cb), .right_nc_cr(right_nc_cr),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    // Clock / timebase: inputs change and outputs are sampled 1 ns after each rising edge.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    int              n_cmp = 0;
    int              n_err = 0;
    logic [CW-1:0]   exp_q[$];
    logic [BW-1:0]   bel_a [0:255];
    logic [BW-1:0]   rgt_a [0:255];

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] observed_ctx();
        return {mby, mbx, abv_out_of_pic, left_out_of_pic,
                above_nc_cr, above_nc_cb, above_nc_y, left_nc_cr, left_nc_cb, left_nc_y};
    endfunction

    // Reference model: pick every MB's below/right data up front, then list the contexts the
    // frame must present in raster order.
    task automatic build_model(input int w, input int h, input bit fill_ff, input bit directed);
        logic [BW-1:0] ab, lf;
        for (int i = 0; i < w * h; i++) begin
            bel_a[i] = fill_ff ? {BW{1'b1}} : {$urandom, $urandom};
            rgt_a[i] = fill_ff ? {BW{1'b1}} : {$urandom, $urandom};
        end
        if (directed && w >= 3) begin
            bel_a[1][31:0] = 32'h04030201;
            rgt_a[2][31:0] = 32'h0A0B0C0D;
        end
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                ab = (y == 0) ? '0 : bel_a[(y - 1) * w + x];
                lf = (x == 0) ? '0 : rgt_a[y * w + x - 1];
                exp_q.push_back({DIM_W'(y), DIM_W'(x), (y == 0), (x == 0), ab, lf});
            end
        end
    endtask

    task automatic drive_done(input int idx);
        mb_done     = 1'b1;
        below_nc_y  = bel_a[idx][31:0];
        below_nc_cb = bel_a[idx][47:32];
        below_nc_cr = bel_a[idx][63:48];
        right_nc_y  = rgt_a[idx][31:0];
        right_nc_cb = rgt_a[idx][47:32];
        right_nc_cr = rgt_a[idx][63:48];
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctx"}, observed_ctx(), '0);
        check_eq({tag, "_flags"}, CW'({ctx_valid, busy, frame_done, cfg_err}), '0);
    endtask

    task automatic run_frame(input int w, input int h, input bit fill_ff, input bit directed,
                             input int abort_idx);
        logic [CW-1:0] exp;
        int n, exp_lat, stall;
        bit hold;
        build_model(w, h, fill_ff, directed);
        pic_width_mb  = DIM_W'(w);
        pic_height_mb = DIM_W'(h);
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        check_eq("busy_after_start", CW'(busy), CW'(1));
        check_eq("ctx_in_load", CW'(ctx_valid), '0);
        // mb_done during LOAD must be ignored
        drive_done(0);
        tick();
        mb_done = 1'b0;
        exp_lat = 0;
        for (int i = 0; i < w * h; i++) begin
            n = 0;
            while (!ctx_valid && n < 8) begin
                tick();
                n++;
            end
            check_eq("ctx_wait", CW'(ctx_valid), CW'(1));
            if (!ctx_valid) return;
            check_eq("ctx_latency", CW'(n), CW'(exp_lat));
            exp = exp_q.pop_front();
            check_eq("ctx", observed_ctx(), exp);
            if (i == abort_idx) begin
                #2 reset_n = 1'b0;
                #1 check_all_zero("async_reset");
                #3 tick();
                reset_n = 1'b1;
                repeat (3) begin
                    tick();
                    check_all_zero("post_reset");
                end
                return;
            end
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                if (s == 0) begin
                    pic_width_mb  = 8'd7;
                    pic_height_mb = 8'd7;
                    frame_start   = 1'b1;
                end
                tick();
                frame_start = 1'b0;
                check_eq("ctx_stable", observed_ctx(), exp);
                check_eq("ctx_valid_stable", CW'(ctx_valid), CW'(1));
            end
            hold = (i != w * h - 1) && ($urandom_range(0, 3) == 0);
            drive_done(i);
            tick();
            if (hold) begin
                tick();
                tick();
            end
            mb_done = 1'b0;
            if (i == w * h - 1) begin
                check_eq("write_last", CW'({ctx_valid, busy, frame_done}), CW'(3'b010));
                tick();
                check_eq("frame_done_pulse", CW'({ctx_valid, busy, frame_done}), CW'(3'b001));
                tick();
                check_eq("frame_done_end", CW'({busy, frame_done}), '0);
            end else begin
                exp_lat = hold ? 0 : 2;
            end
        end
    endtask

    task automatic cfg_bad(input int w, input int h);
        pic_width_mb  = DIM_W'(w);
        pic_height_mb = DIM_W'(h);
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        check_eq("cfg_err_pulse", CW'({cfg_err, busy}), CW'(2'b10));
        tick();
        check_eq("cfg_err_end", CW'({cfg_err, busy}), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        frame_start   = 1'b0;
        pic_width_mb  = '0;
        pic_height_mb = '0;
        mb_done       = 1'b0;
        below_nc_y = '0; below_nc_cb = '0; below_nc_cr = '0;
        right_nc_y = '0; right_nc_cb = '0; right_nc_cr = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        mb_done = 1'b1;
        tick();
        mb_done = 1'b0;
        check_eq("mb_done_idle", CW'({busy, ctx_valid}), '0);

        run_frame(3, 2, 1'b1, 1'b0, -1);
        run_frame(3, 2, 1'b0, 1'b1, -1);
        cfg_bad(0, 2);
        cfg_bad(121, 1);
        cfg_bad(4, 0);
        run_frame(120, 1, 1'b0, 1'b0, -1);
        run_frame(1, 4, 1'b0, 1'b0, -1);
        repeat (4) run_frame($urandom_range(1, 8), $urandom_range(1, 6), 1'b0, 1'b0, -1);
        run_frame(3, 2, 1'b0, 1'b0, 4);
        run_frame(1, 1, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
